// File: rtl/fht_but_pipe.sv
// Radix-2 FHT butterfly: y0/y1 = x0 +/- (cos*x1 + sin*x2), three register stages,
// valid/ready flow control with a global stall, optional halving, output saturation
// and a saturating count of clipped output samples.
module fht_but_pipe #(
    parameter int unsigned D_BIT      = 16,
    parameter int unsigned W_BIT      = 16,
    parameter int unsigned SCALE_MODE = 1,
    parameter int unsigned OVF_BIT    = 16
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic                      iVALID,
    output logic                      oREADY,
    input  logic signed [D_BIT-1:0]   iX_0,
    input  logic signed [D_BIT-1:0]   iX_1,
    input  logic signed [D_BIT-1:0]   iX_2,
    input  logic signed [W_BIT-1:0]   iSIN,
    input  logic signed [W_BIT-1:0]   iCOS,
    output logic                      oVALID,
    input  logic                      iREADY,
    output logic signed [D_BIT-1:0]   oY_0,
    output logic signed [D_BIT-1:0]   oY_1,
    output logic                      oOVF,
    input  logic                      iCLR_CNT,
    output logic [OVF_BIT-1:0]        oOVF_CNT
);

    localparam int unsigned P_BIT = D_BIT + W_BIT;   // product width
    localparam int unsigned S_BIT = P_BIT + 1;       // product sum width
    localparam int unsigned T_BIT = D_BIT + 2;       // rotated term width
    localparam int unsigned A_BIT = D_BIT + 3;       // exact butterfly width
    localparam int unsigned SHIFT = W_BIT - 2;       // twiddle unity exponent

    localparam logic signed [S_BIT-1:0] RND   = S_BIT'(2 ** (W_BIT - 3));
    localparam logic signed [A_BIT-1:0] ONE_A = A_BIT'(1);
    localparam logic signed [A_BIT-1:0] MAX_A = A_BIT'((2 ** (D_BIT - 1)) - 1);
    localparam logic signed [A_BIT-1:0] MIN_A = -MAX_A - ONE_A;

    logic                      en;
    logic                      v1;
    logic                      v2;
    logic signed [P_BIT-1:0]   p1_q;
    logic signed [P_BIT-1:0]   p2_q;
    logic signed [D_BIT-1:0]   x0_1;
    logic signed [D_BIT-1:0]   x0_2;
    logic signed [S_BIT-1:0]   s_c;
    logic signed [T_BIT-1:0]   t_c;
    logic signed [T_BIT-1:0]   t_q;
    logic signed [A_BIT-1:0]   a_c;
    logic signed [A_BIT-1:0]   b_c;
    logic signed [A_BIT-1:0]   as_c;
    logic signed [A_BIT-1:0]   bs_c;
    logic signed [D_BIT-1:0]   ya_c;
    logic signed [D_BIT-1:0]   yb_c;
    logic                      clip_a;
    logic                      clip_b;

    // Whole pipeline advances together unless a valid output is being held
    assign en     = iREADY | ~oVALID;
    assign oREADY = en;

    // S1: twiddle products, x0 delayed alongside
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v1   <= 1'b0;
            p1_q <= '0;
            p2_q <= '0;
            x0_1 <= '0;
        end else if (en) begin
            v1 <= iVALID;
            if (iVALID) begin
                p1_q <= P_BIT'(iCOS) * P_BIT'(iX_1);
                p2_q <= P_BIT'(iSIN) * P_BIT'(iX_2);
                x0_1 <= iX_0;
            end
        end
    end

    // S2 combinational: sum products and rescale by the twiddle unity with rounding
    always_comb begin
        s_c = S_BIT'(p1_q) + S_BIT'(p2_q) + RND;
        t_c = T_BIT'(s_c >>> SHIFT);
    end

    // S2: rotated term register
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v2   <= 1'b0;
            t_q  <= '0;
            x0_2 <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                t_q  <= t_c;
                x0_2 <= x0_1;
            end
        end
    end

    // S3 combinational: exact butterfly, optional round-half-up halving
    always_comb begin
        a_c  = A_BIT'(x0_2) + A_BIT'(t_q);
        b_c  = A_BIT'(x0_2) - A_BIT'(t_q);
        as_c = (SCALE_MODE != 0) ? ((a_c + ONE_A) >>> 1) : a_c;
        bs_c = (SCALE_MODE != 0) ? ((b_c + ONE_A) >>> 1) : b_c;
    end

    // S3 combinational: clamp both results into the output range
    always_comb begin
        ya_c   = as_c[D_BIT-1:0];
        yb_c   = bs_c[D_BIT-1:0];
        clip_a = 1'b0;
        clip_b = 1'b0;
        if (as_c > MAX_A) begin
            ya_c   = MAX_A[D_BIT-1:0];
            clip_a = 1'b1;
        end else if (as_c < MIN_A) begin
            ya_c   = MIN_A[D_BIT-1:0];
            clip_a = 1'b1;
        end
        if (bs_c > MAX_A) begin
            yb_c   = MAX_A[D_BIT-1:0];
            clip_b = 1'b1;
        end else if (bs_c < MIN_A) begin
            yb_c   = MIN_A[D_BIT-1:0];
            clip_b = 1'b1;
        end
    end

    // S3: output register, held while downstream stalls
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oVALID <= 1'b0;
            oY_0   <= '0;
            oY_1   <= '0;
            oOVF   <= 1'b0;
        end else if (en) begin
            oVALID <= v2;
            if (v2) begin
                oY_0 <= ya_c;
                oY_1 <= yb_c;
                oOVF <= clip_a | clip_b;
            end
        end
    end

    // Overflow counter: counts transferred clipped samples, sticks at all-ones, clear wins
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOVF_CNT <= '0;
        end else if (iCLR_CNT) begin
            oOVF_CNT <= '0;
        end else if (oVALID && iREADY && oOVF && (oOVF_CNT != '1)) begin
            oOVF_CNT <= oOVF_CNT + OVF_BIT'(1);
        end
    end

endmodule
